// File: rtl/adc_sdram_recorder.sv
// Stereo ADC recorder: pairs left/right 16-bit samples into 32-bit words,
// buffers them in a small FIFO and writes them to consecutive SDRAM addresses.
module adc_sdram_recorder #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_max_words,
    output logic              o_adc_left_ready,
    input  logic              i_adc_left_valid,
    input  logic [15:0]       i_adc_left_data,
    output logic              o_adc_right_ready,
    input  logic              i_adc_right_valid,
    input  logic [15:0]       i_adc_right_data,
    output logic [ADDR_W-1:0] o_sdram_address,
    output logic [3:0]        o_sdram_byteenable_n,
    output logic              o_sdram_chipselect,
    output logic [31:0]       o_sdram_writedata,
    output logic              o_sdram_write_n,
    output logic              o_sdram_read_n,
    input  logic              i_sdram_waitrequest,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_words_written,
    output logic              o_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FILL_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FILL_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [ADDR_W-1:0]  max_r, count_r, addr_r, count_next_s;
    logic               overflow_r;
    logic               left_full_r, right_full_r;
    logic [15:0]        left_data_r, right_data_r;
    logic [31:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     fill_r, fill_after_pop_s, fill_next_s;
    logic               capture_s, active_s, start_s, left_beat_s, right_beat_s;
    logic               pair_s, push_s, drop_s, wr_req_s, pop_s;
    logic [31:0]        pair_data_s;

    // Pairing, FIFO occupancy and writer handshake decode
    always_comb begin
        capture_s        = (state_r == ST_CAPTURE);
        active_s         = capture_s || (state_r == ST_DRAIN);
        start_s          = (state_r == ST_IDLE) && i_start;
        left_beat_s      = capture_s && i_adc_left_valid;
        right_beat_s     = capture_s && i_adc_right_valid;
        pair_s           = capture_s && (left_full_r || left_beat_s) && (right_full_r || right_beat_s);
        pair_data_s      = {left_beat_s ? i_adc_left_data : left_data_r,
                            right_beat_s ? i_adc_right_data : right_data_r};
        wr_req_s         = active_s && (fill_r != FILL_ZERO) && (count_r < max_r);
        pop_s            = wr_req_s && !i_sdram_waitrequest;
        fill_after_pop_s = fill_r - {{PTR_W{1'b0}}, pop_s};
        drop_s           = pair_s && (fill_after_pop_s == FILL_FULL);
        push_s           = pair_s && !drop_s;
        fill_next_s      = fill_after_pop_s + {{PTR_W{1'b0}}, push_s};
        count_next_s     = count_r + {{(ADDR_W-1){1'b0}}, pop_s};
    end

    // Next-state logic; reaching the word limit wins over a same-cycle stop
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = (i_max_words == ADDR_ZERO) ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (count_next_s == max_r) begin
                    state_s = ST_DONE;
                end else if (i_stop) begin
                    state_s = (fill_next_s == FILL_ZERO) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if ((count_next_s == max_r) || (fill_next_s == FILL_ZERO)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Recording parameters, word count, write address and overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            max_r      <= ADDR_ZERO;
            count_r    <= ADDR_ZERO;
            addr_r     <= ADDR_ZERO;
            overflow_r <= 1'b0;
        end else if (start_s) begin
            max_r      <= i_max_words;
            count_r    <= ADDR_ZERO;
            addr_r     <= i_base_addr;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            addr_r     <= pop_s ? (addr_r + ADDR_ONE) : addr_r;
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Left/right half-pair latches; anything partial is dropped outside capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left_full_r  <= 1'b0;
            right_full_r <= 1'b0;
            left_data_r  <= 16'h0000;
            right_data_r <= 16'h0000;
        end else if (!capture_s || pair_s) begin
            left_full_r  <= 1'b0;
            right_full_r <= 1'b0;
        end else begin
            if (left_beat_s) begin
                left_full_r <= 1'b1;
                left_data_r <= i_adc_left_data;
            end
            if (right_beat_s) begin
                right_full_r <= 1'b1;
                right_data_r <= i_adc_right_data;
            end
        end
    end

    // FIFO pointers and fill level; DONE flushes whatever is left
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= FILL_ZERO;
        end else if (state_r == ST_DONE) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= FILL_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, push_s};
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
            fill_r   <= fill_next_s;
        end
    end

    // FIFO storage
    always_ff @(posedge i_clk) begin
        if (push_s) mem_r[wr_ptr_r] <= pair_data_s;
    end

    assign o_adc_left_ready     = capture_s;
    assign o_adc_right_ready    = capture_s;
    assign o_sdram_address      = addr_r;
    assign o_sdram_byteenable_n = 4'b0000;
    assign o_sdram_chipselect   = wr_req_s;
    assign o_sdram_writedata    = wr_req_s ? mem_r[rd_ptr_r] : 32'h0000_0000;
    assign o_sdram_write_n      = ~wr_req_s;
    assign o_sdram_read_n       = 1'b1;
    assign o_busy               = active_s;
    assign o_done               = (state_r == ST_DONE);
    assign o_words_written      = count_r;
    assign o_overflow           = overflow_r;
endmodule

// File: tb/tb_adc_sdram_recorder.sv
// Self-checking bench for adc_sdram_recorder: random stimulus compared cycle by
// cycle against a queue-based behavioural model of the recorder.
`timescale 1ns/1ps
module tb_adc_sdram_recorder;
    localparam int ADDR_W = 25;
    localparam int DEPTH  = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n, i_start, i_stop, i_sdram_waitrequest;
    logic [ADDR_W-1:0] i_base_addr, i_max_words;
    logic              o_adc_left_ready, i_adc_left_valid, o_adc_right_ready, i_adc_right_valid;
    logic [15:0]       i_adc_left_data, i_adc_right_data;
    logic [ADDR_W-1:0] o_sdram_address, o_words_written;
    logic [3:0]        o_sdram_byteenable_n;
    logic              o_sdram_chipselect, o_sdram_write_n, o_sdram_read_n;
    logic              o_busy, o_done, o_overflow;
    logic [31:0]       o_sdram_writedata;

    always #10 i_clk = ~i_clk;

    adc_sdram_recorder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_base_addr(i_base_addr), .i_max_words(i_max_words),
        .o_adc_left_ready(o_adc_left_ready), .i_adc_left_valid(i_adc_left_valid),
        .i_adc_left_data(i_adc_left_data),
        .o_adc_right_ready(o_adc_right_ready), .i_adc_right_valid(i_adc_right_valid),
        .i_adc_right_data(i_adc_right_data),
        .o_sdram_address(o_sdram_address), .o_sdram_byteenable_n(o_sdram_byteenable_n),
        .o_sdram_chipselect(o_sdram_chipselect), .o_sdram_writedata(o_sdram_writedata),
        .o_sdram_write_n(o_sdram_write_n), .o_sdram_read_n(o_sdram_read_n),
        .i_sdram_waitrequest(i_sdram_waitrequest),
        .o_busy(o_busy), .o_done(o_done), .o_words_written(o_words_written),
        .o_overflow(o_overflow)
    );

    typedef struct {
        logic st, sp, lv, rv;
        logic [15:0] ld, rd;
    } stim_t;

    int errors = 0;
    int checks = 0;
    stim_t sq[$];
    logic [ADDR_W-1:0] st_base, st_max;

    // Accepted writes as seen on the bus
    int acc_cnt = 0;
    logic [ADDR_W-1:0] mon_addr[$];
    logic [31:0]       mon_data[$];
    always @(negedge i_clk) begin
        if (i_rst_n && o_sdram_chipselect && !o_sdram_write_n && !i_sdram_waitrequest) begin
            acc_cnt++;
            mon_addr.push_back(o_sdram_address);
            mon_data.push_back(o_sdram_writedata);
        end
    end

    // Behavioural model state
    bit                m_busy, m_capt, m_done, m_ovf, m_lf, m_rf;
    logic [ADDR_W-1:0] m_base, m_max, m_count;
    logic [15:0]       m_ld, m_rd;
    logic [31:0]       m_q[$];
    int                m_acc = 0;

    logic [6:0]        exp_ctl, obs_ctl;
    logic [ADDR_W-1:0] exp_ww, obs_ww, exp_addr, obs_addr;
    logic [31:0]       exp_data, obs_data;
    bit                exp_req;

    function automatic stim_t mk(bit st, bit sp, bit lv, logic [15:0] ld, bit rv, logic [15:0] rd);
        stim_t s;
        s.st = st; s.sp = sp; s.lv = lv; s.ld = ld; s.rv = rv; s.rd = rd;
        return s;
    endfunction

    function automatic bit model_req();
        return m_busy && (m_q.size() > 0) && (m_count < m_max);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_capt = 0; m_done = 0; m_ovf = 0; m_lf = 0; m_rf = 0;
        m_base = '0; m_max = '0; m_count = '0;
        m_q.delete();
    endfunction

    function automatic void model_update(stim_t s, bit wr, bit req);
        bit pair = 0;
        bit fin = 0;
        logic [31:0] pd = 32'h0;
        if (m_done) begin
            m_done = 0; m_q.delete(); m_lf = 0; m_rf = 0;
        end else if (!m_busy) begin
            if (s.st) begin
                m_base = st_base; m_max = st_max; m_count = '0; m_ovf = 0; m_lf = 0; m_rf = 0;
                if (st_max == '0) m_done = 1;
                else begin m_busy = 1; m_capt = 1; end
            end
        end else begin
            if (m_capt) begin
                if (s.lv) begin m_lf = 1; m_ld = s.ld; end
                if (s.rv) begin m_rf = 1; m_rd = s.rd; end
                if (m_lf && m_rf) begin pair = 1; pd = {m_ld, m_rd}; m_lf = 0; m_rf = 0; end
            end
            if (req && !wr) begin
                void'(m_q.pop_front()); m_count++; m_acc++;
            end
            if (pair) begin
                if (m_q.size() < DEPTH) m_q.push_back(pd);
                else m_ovf = 1;
            end
            if (m_capt) begin
                if (m_count == m_max) fin = 1;
                else if (s.sp) begin
                    m_capt = 0; m_lf = 0; m_rf = 0;
                    if (m_q.size() == 0) fin = 1;
                end
            end else if (m_count == m_max || m_q.size() == 0) fin = 1;
            if (fin) begin m_busy = 0; m_capt = 0; m_done = 1; end
        end
    endfunction

    // Drive one cycle of stimulus, snapshot DUT and model expectations, advance model
    task automatic step(input stim_t s, input bit wr);
        i_start = s.st; i_stop = s.sp;
        i_adc_left_valid = s.lv; i_adc_left_data = s.ld;
        i_adc_right_valid = s.rv; i_adc_right_data = s.rd;
        i_sdram_waitrequest = wr; i_base_addr = st_base; i_max_words = st_max;
        exp_req  = model_req();
        exp_ctl  = {exp_req, !exp_req, m_capt, m_capt, m_busy, m_done, m_ovf};
        exp_ww   = m_count;
        exp_addr = m_base + m_count;
        exp_data = exp_req ? m_q[0] : 32'h0;
        @(negedge i_clk);
        obs_ctl  = {o_sdram_chipselect, o_sdram_write_n, o_adc_left_ready, o_adc_right_ready,
                    o_busy, o_done, o_overflow};
        obs_ww   = o_words_written;
        obs_addr = o_sdram_address;
        obs_data = o_sdram_writedata;
        model_update(s, wr, exp_req);
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_adc_left_ready, o_adc_right_ready, o_sdram_chipselect, o_sdram_write_n, o_sdram_read_n,
             o_busy, o_done, o_overflow} !== 8'b0001_1000 || o_sdram_byteenable_n !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl got=%b be=%b", {o_adc_left_ready, o_adc_right_ready,
                     o_sdram_chipselect, o_sdram_write_n, o_sdram_read_n, o_busy, o_done, o_overflow},
                     o_sdram_byteenable_n);
        end
        checks++;
        if (o_sdram_address !== '0 || o_sdram_writedata !== 32'h0 || o_words_written !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h data=%h ww=%0d", o_sdram_address, o_sdram_writedata, o_words_written);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            step(mk(0, 1, 1, 16'h1234, 1, 16'h5678), 1'b0);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL reset_idle c=%0d ctl=%b exp %b ww=%0d exp %0d", c, obs_ctl, exp_ctl, obs_ww, exp_ww);
            end
        end
    endtask

    task automatic test_basic();
        int base_acc = acc_cnt;
        mon_addr.delete(); mon_data.delete();
        st_base = 25'h100; st_max = 25'd4;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int k = 1; k <= 4; k++) sq.push_back(mk(0, 0, 1, 16'(16'h1111 * k), 1, 16'(16'h2222 * k)));
        for (int c = 0; c < 60; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, 1'b0);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL basic_cycle c=%0d ctl=%b exp %b ww=%0d exp %0d addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_ww, exp_ww, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        for (int c = 0; c < 5; c++) begin
            step(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)), 1'b0);
            checks++;
            if ({obs_ctl, obs_ww} !== {exp_ctl, exp_ww}) begin
                errors++;
                $display("FAIL basic_after c=%0d ctl=%b exp %b ww=%0d exp %0d", c, obs_ctl, exp_ctl, obs_ww, exp_ww);
            end
        end
        checks++;
        if (acc_cnt - base_acc != 4 || o_words_written !== 25'd4 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_totals writes=%0d ww=%0d ovf=%b need 4/4/0", acc_cnt - base_acc, o_words_written, o_overflow);
        end
        for (int i = 0; i < 4 && i < mon_addr.size(); i++) begin
            logic [31:0] want = {16'(16'h1111 * (i + 1)), 16'(16'h2222 * (i + 1))};
            checks++;
            if (mon_addr[i] !== 25'h100 + 25'(i) || mon_data[i] !== want) begin
                errors++;
                $display("FAIL basic_word i=%0d addr=%h data=%h need %h/%h", i, mon_addr[i], mon_data[i], 25'h100 + 25'(i), want);
            end
        end
    endtask

    task automatic test_wait();
        int base_acc = acc_cnt;
        int stall = 0;
        st_base = 25'($urandom); st_max = 25'd60;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int k = 0; k < 20; k++) sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        sq.push_back(mk(0, 1, 0, 16'h0, 0, 16'h0));
        for (int c = 0; c < 400; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            bit req = model_req();
            bit wr = req && (stall < 3);
            if (wr) stall++;
            else if (req) stall = 0;
            step(s, wr);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL wait_cycle c=%0d ctl=%b exp %b ww=%0d exp %0d addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_ww, exp_ww, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        checks++;
        if (m_busy || m_done || o_overflow !== 1'b1 || acc_cnt - base_acc != int'(o_words_written)) begin
            errors++;
            $display("FAIL wait_totals busy=%b ovf=%b need 1 writes=%0d ww=%0d", m_busy, o_overflow, acc_cnt - base_acc, o_words_written);
        end
    endtask

    task automatic test_stop();
        int base_acc = acc_cnt;
        st_base = 25'($urandom); st_max = 25'd100;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int p = 0; p < 5; p++) begin
            logic [15:0] l = 16'($urandom);
            logic [15:0] r = 16'($urandom);
            case ($urandom_range(0, 2))
                0: sq.push_back(mk(0, 0, 1, l, 1, r));
                1: begin
                    sq.push_back(mk(0, 0, 1, l, 0, 16'h0));
                    sq.push_back(mk(0, 0, 0, 16'h0, 0, 16'h0));
                    sq.push_back(mk(0, 0, 0, 16'h0, 1, r));
                end
                default: begin
                    sq.push_back(mk(0, 0, 1, 16'($urandom), 0, 16'h0));
                    sq.push_back(mk(0, 0, 1, l, 0, 16'h0));
                    sq.push_back(mk(0, 0, 0, 16'h0, 1, r));
                end
            endcase
        end
        sq.push_back(mk(0, 0, 1, 16'($urandom), 0, 16'h0));
        sq.push_back(mk(0, 0, 0, 16'h0, 0, 16'h0));
        sq.push_back(mk(0, 1, 0, 16'h0, 0, 16'h0));
        for (int c = 0; c < 200; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, $urandom_range(0, 2) == 0);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL stop_cycle c=%0d ctl=%b exp %b ww=%0d exp %0d addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_ww, exp_ww, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        checks++;
        if (m_busy || m_done || acc_cnt - base_acc != 5 || o_words_written !== 25'd5) begin
            errors++;
            $display("FAIL stop_totals writes=%0d ww=%0d need 5", acc_cnt - base_acc, o_words_written);
        end
    endtask

    task automatic test_wrap();
        int base_acc;
        int done_at = -1;
        mon_addr.delete(); mon_data.delete();
        st_base = {ADDR_W{1'b1}} - 25'd1; st_max = 25'd4;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int k = 0; k < 4; k++) sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        for (int c = 0; c < 60; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, 1'b0);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL wrap_cycle c=%0d ctl=%b exp %b addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        checks++;
        if (mon_addr.size() != 4 || mon_addr[0] !== 25'h1FFFFFE || mon_addr[1] !== 25'h1FFFFFF ||
            mon_addr[2] !== 25'h0 || mon_addr[3] !== 25'h1) begin
            errors++;
            $display("FAIL wrap_addrs n=%0d a0=%h a1=%h a2=%h a3=%h", mon_addr.size(),
                     mon_addr[0], mon_addr[1], mon_addr[2], mon_addr[3]);
        end
        base_acc = acc_cnt;
        st_max = 25'd0;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int c = 0; c < 6; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, 1'b0);
            if (obs_ctl[1] === 1'b1 && done_at < 0) done_at = c;
            checks++;
            if ({obs_ctl, obs_ww, obs_addr} !== {exp_ctl, exp_ww, exp_addr}) begin
                errors++;
                $display("FAIL zero_cycle c=%0d ctl=%b exp %b ww=%0d exp %0d", c, obs_ctl, exp_ctl, obs_ww, exp_ww);
            end
        end
        checks++;
        if (done_at != 1 || acc_cnt != base_acc) begin
            errors++;
            $display("FAIL zero_len done_at=%0d need 1 writes=%0d need 0", done_at, acc_cnt - base_acc);
        end
    endtask

    task automatic test_reset_mid();
        int nreq = 0;
        int base_acc;
        st_base = 25'($urandom); st_max = 25'd10;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        for (int c = 0; c < 20 && nreq < 2; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, 1'b1);
            if (exp_req) nreq++;
            checks++;
            if ({obs_ctl, obs_addr, obs_data} !== {exp_ctl, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL rstmid_cycle c=%0d ctl=%b exp %b addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_addr, exp_addr, obs_data, exp_data);
            end
        end
        sq.delete();
        checks++;
        if (nreq < 2 || o_sdram_write_n !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup nreq=%0d write_n=%b need 0", nreq, o_sdram_write_n);
        end
        #4;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_sdram_write_n !== 1'b1 || o_sdram_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async write_n=%b cs=%b need 1/0", o_sdram_write_n, o_sdram_chipselect);
        end
        checks++;
        if ({o_adc_left_ready, o_adc_right_ready, o_busy, o_done, o_overflow, o_sdram_read_n} !== 6'b000001 ||
            o_sdram_address !== '0 || o_sdram_writedata !== 32'h0 || o_words_written !== '0) begin
            errors++;
            $display("FAIL rstmid_values rdy=%b%b busy=%b done=%b ovf=%b addr=%h data=%h ww=%0d",
                     o_adc_left_ready, o_adc_right_ready, o_busy, o_done, o_overflow,
                     o_sdram_address, o_sdram_writedata, o_words_written);
        end
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        mon_addr.delete(); mon_data.delete();
        base_acc = acc_cnt;
        st_base = 25'($urandom); st_max = 25'd3;
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int k = 0; k < 3; k++) sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        for (int c = 0; c < 100; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, $urandom_range(0, 1) == 0);
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL rstmid_after c=%0d ctl=%b exp %b addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        checks++;
        if (acc_cnt - base_acc != 3 || mon_addr.size() != 3 || mon_addr[0] !== st_base || mon_addr[2] !== st_base + 25'd2) begin
            errors++;
            $display("FAIL rstmid_record writes=%0d first=%h need 3 from %h", acc_cnt - base_acc, mon_addr[0], st_base);
        end
    endtask

    task automatic test_simul();
        logic [ADDR_W-1:0] b1 = 25'($urandom);
        mon_addr.delete(); mon_data.delete();
        st_base = b1; st_max = 25'd6;
        sq.push_back(mk(1, 1, 0, 16'h0, 0, 16'h0));
        for (int k = 0; k < 3; k++) sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        sq.push_back(mk(1, 0, 0, 16'h0, 0, 16'h0));
        for (int k = 0; k < 3; k++) sq.push_back(mk(0, 0, 1, 16'($urandom), 1, 16'($urandom)));
        for (int c = 0; c < 100; c++) begin
            stim_t s = (sq.size() > 0) ? sq.pop_front() : mk(0, 0, 0, 16'h0, 0, 16'h0);
            step(s, 1'b0);
            if (c == 0) st_base = b1 + 25'h40;
            checks++;
            if ({obs_ctl, obs_ww, obs_addr, obs_data} !== {exp_ctl, exp_ww, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL simul_cycle c=%0d ctl=%b exp %b addr=%h exp %h data=%h exp %h",
                         c, obs_ctl, exp_ctl, obs_addr, exp_addr, obs_data, exp_data);
            end
            if (sq.size() == 0 && !m_busy && !m_done) break;
        end
        checks++;
        if (mon_addr.size() != 6 || mon_addr[0] !== b1 || mon_addr[5] !== b1 + 25'd5 || o_words_written !== 25'd6) begin
            errors++;
            $display("FAIL simul_record n=%0d first=%h need 6 from %h ww=%0d", mon_addr.size(), mon_addr[0], b1, o_words_written);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_sdram_waitrequest = 1'b0;
        i_adc_left_valid = 1'b0; i_adc_right_valid = 1'b0;
        i_adc_left_data = 16'h0; i_adc_right_data = 16'h0;
        st_base = '0; st_max = '0;
        i_base_addr = '0; i_max_words = '0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        test_reset();
        test_basic();
        test_wait();
        test_stop();
        test_wrap();
        test_reset_mid();
        test_simul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
